pb_prog_load_ctrl: RTL and testbench

- Sequences loading of PicoBlaze instruction BRAMs through the shared jtag-style program-memory port: one enable per core, plus common we, addr, din and clk.
- Accepts a load command and an 18-bit instruction stream from a host-side source.
- Holds the target core in reset while it loads, writes the image, then verifies it by checksum readback before releasing reset.
- Sits between the host/debug interface and the per-core BRAM ports, beside the JTAG loader path.

---
 rtl/pb_debug_pkg.sv | 32 +++
 rtl/pb_prog_load_ctrl_if.sv | 29 ++
 rtl/pb_rd_pipe.sv | 51 +++++
 rtl/pb_prog_load_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pb_prog_load_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pb_debug_pkg.sv
// Shared types and constants for the PicoBlaze program-load path.
// State encoding, error codes and instruction-word helpers.
package pb_debug_pkg;

    localparam int MAX_JTAG_CHAIN_CNT = 8;
    localparam int PB_INSTR_W         = 18;
    localparam int TGT_W              = $clog2(MAX_JTAG_CHAIN_CNT);

    typedef logic [PB_INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        ERR_OK  = 2'd0,
        ERR_CMD = 2'd1,
        ERR_SUM = 2'd2
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WRITE,
        S_RDISS,
        S_RDWAIT,
        S_CMP,
        S_RELEASE
    } ld_state_e;

    // Checksum is a plain 18-bit modular sum of instruction words.
    function automatic instr_t csum_add(instr_t a, instr_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/pb_prog_load_ctrl_if.sv
// Host-side command and instruction-stream handshake bundle.
// master = host/debug source, slave = load controller.
interface pb_prog_load_ctrl_if #(
    parameter int BRAM_ADDRESS_WIDTH = 10
);
    import pb_debug_pkg::*;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [TGT_W-1:0]            cmd_target;
    logic [BRAM_ADDRESS_WIDTH:0] cmd_len;
    logic                        cmd_verify;
    logic                        s_valid;
    logic                        s_ready;
    instr_t                      s_data;

    modport master (
        output cmd_valid, cmd_target, cmd_len, cmd_verify,
        output s_valid, s_data,
        input  cmd_ready, s_ready
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_len, cmd_verify,
        input  s_valid, s_data,
        output cmd_ready, s_ready
    );

endinterface

// File: rtl/pb_rd_pipe.sv
// Tracks BRAM reads in flight and accumulates returned words.
// dout is summed exactly RD_LATENCY cycles after each issue.
module pb_rd_pipe
    import pb_debug_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   issue,
    input  logic   clear,
    input  instr_t dout,
    output instr_t rsum,
    output logic   pending
);

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    instr_t                rsum_q, rsum_d;

    // Shift issue tokens and add dout when a token reaches the end.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        rsum_d = rsum_q;
        if (vld_q[RD_LATENCY-1]) begin
            rsum_d = csum_add(rsum_q, dout);
        end
        if (clear) begin
            vld_d  = '0;
            rsum_d = '0;
        end
    end

    // Token and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            rsum_q <= '0;
        end else begin
            vld_q  <= vld_d;
            rsum_q <= rsum_d;
        end
    end

    assign rsum    = rsum_q;
    assign pending = |vld_q;

endmodule

// File: rtl/pb_prog_load_ctrl.sv
// Loads a PicoBlaze instruction BRAM while holding its core in reset,
// optionally verifies by checksum readback, then releases the core.
module pb_prog_load_ctrl
    import pb_debug_pkg::*;
#(
    parameter int C_NUM_PICOBLAZE    = 8,
    parameter int BRAM_ADDRESS_WIDTH = 10,
    parameter int RST_HOLD_CYCLES    = 4,
    parameter int RD_LATENCY         = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    pb_prog_load_ctrl_if.slave                   bus,
    output logic                                 bram_clk,
    output logic [C_NUM_PICOBLAZE-1:0]           bram_en,
    output logic                                 bram_we,
    output logic [BRAM_ADDRESS_WIDTH-1:0]        bram_addr,
    output instr_t                               bram_din,
    input  logic [C_NUM_PICOBLAZE*PB_INSTR_W-1:0] bram_dout,
    output logic [C_NUM_PICOBLAZE-1:0]           pb_reset,
    output logic                                 busy,
    output logic                                 done,
    output logic [1:0]                           err
);

    localparam int NP = C_NUM_PICOBLAZE;
    localparam int AW = BRAM_ADDRESS_WIDTH;
    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [AW:0]      LEN_MAX   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [TGT_W:0]   TGT_LIM   = (TGT_W+1)'(NP);

    ld_state_e        state_q, state_d;
    logic [TGT_W-1:0] tgt_q, tgt_d;
    logic [AW:0]      len_q, len_d;
    logic             vfy_q, vfy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [HW-1:0]    hold_q, hold_d;
    instr_t           sum_q, sum_d;
    err_e             err_q, err_d;
    logic             done_q, done_d;
    logic [NP-1:0]    pbr_q, pbr_d;

    logic             cmd_bad;
    logic             rd_issue;
    logic             pipe_clr;
    logic             rd_pend;
    logic [NP-1:0]    tgt_oh;
    instr_t           dout_sel;
    instr_t           rsum;

    function automatic logic [NP-1:0] onehot(logic [TGT_W-1:0] t);
        logic [NP-1:0] oh;
        for (int i = 0; i < NP; i++) begin
            oh[i] = (t == TGT_W'(i));
        end
        return oh;
    endfunction

    assign tgt_oh   = onehot(tgt_q);
    assign cmd_bad  = ({1'b0, bus.cmd_target} >= TGT_LIM)
                   || (bus.cmd_len == '0)
                   || (bus.cmd_len > LEN_MAX);
    assign rd_issue = (state_q == S_RDISS);

    // Select the readback word of the core being loaded.
    always_comb begin
        dout_sel = '0;
        for (int i = 0; i < NP; i++) begin
            if (tgt_q == TGT_W'(i)) begin
                dout_sel = bram_dout[i*PB_INSTR_W +: PB_INSTR_W];
            end
        end
    end

    pb_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .issue   (rd_issue),
        .clear   (pipe_clr),
        .dout    (dout_sel),
        .rsum    (rsum),
        .pending (rd_pend)
    );

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        len_d    = len_q;
        vfy_d    = vfy_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        sum_d    = sum_q;
        err_d    = err_q;
        done_d   = 1'b0;
        pbr_d    = pbr_q;
        pipe_clr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    tgt_d = bus.cmd_target;
                    len_d = bus.cmd_len;
                    vfy_d = bus.cmd_verify;
                    err_d = ERR_OK;
                    if (cmd_bad) begin
                        err_d  = ERR_CMD;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                        pbr_d   = pbr_q | onehot(bus.cmd_target);
                    end
                end
            end
            S_HOLD: begin
                hold_d = hold_q + HOLD_ONE;
                if (hold_q == HOLD_LAST) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            S_WRITE: begin
                if (bus.s_valid) begin
                    sum_d = csum_add(sum_q, bus.s_data);
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == len_q - CNT_ONE) begin
                        if (vfy_q) begin
                            state_d  = S_RDISS;
                            cnt_d    = '0;
                            pipe_clr = 1'b1;
                        end else begin
                            state_d = S_RELEASE;
                            hold_d  = '0;
                        end
                    end
                end
            end
            S_RDISS: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == len_q - CNT_ONE) begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (!rd_pend) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (rsum != sum_q) begin
                    err_d   = ERR_SUM;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RELEASE;
                    hold_d  = '0;
                end
            end
            S_RELEASE: begin
                hold_d = hold_q + HOLD_ONE;
                if (hold_q == HOLD_LAST) begin
                    pbr_d   = pbr_q & ~tgt_oh;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // BRAM port drive: writes follow the accepted word, reads stream.
    always_comb begin
        bram_en   = '0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        if (state_q == S_WRITE && bus.s_valid) begin
            bram_en   = tgt_oh;
            bram_we   = 1'b1;
            bram_addr = cnt_q[AW-1:0];
            bram_din  = bus.s_data;
        end else if (state_q == S_RDISS) begin
            bram_en   = tgt_oh;
            bram_addr = cnt_q[AW-1:0];
        end
    end

    // Sequencer state and command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            len_q   <= '0;
            vfy_q   <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= '0;
            sum_q   <= '0;
            err_q   <= ERR_OK;
            done_q  <= 1'b0;
            pbr_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
            vfy_q   <= vfy_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pbr_q   <= pbr_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.s_ready   = (state_q == S_WRITE);
    assign bram_clk      = clk;
    assign pb_reset      = pbr_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_pb_prog_load_ctrl.sv
// Directed bench for pb_prog_load_ctrl with a per-core BRAM model.
// Command vectors come from a table; reset-abort is hand sequenced.
module tb_pb_prog_load_ctrl;
    import pb_debug_pkg::*;

    localparam int NP   = 4;
    localparam int AW   = 10;
    localparam int HOLD = 4;
    localparam int LAT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pb_prog_load_ctrl_if #(.BRAM_ADDRESS_WIDTH(AW)) bus ();

    logic                 bram_clk;
    logic [NP-1:0]        bram_en;
    logic                 bram_we;
    logic [AW-1:0]        bram_addr;
    logic [17:0]          bram_din;
    logic [NP*18-1:0]     bram_dout;
    logic [NP-1:0]        pb_reset;
    logic                 busy;
    logic                 done;
    logic [1:0]           err;

    pb_prog_load_ctrl #(
        .C_NUM_PICOBLAZE    (NP),
        .BRAM_ADDRESS_WIDTH (AW),
        .RST_HOLD_CYCLES    (HOLD),
        .RD_LATENCY         (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .bram_clk  (bram_clk),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .pb_reset  (pb_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // BRAM model: one memory per core, optional corruption of address 1.
    logic [17:0] mem [NP][1024];
    logic [17:0] r1 [NP];
    logic [17:0] r2 [NP];
    logic        corrupt = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (bram_en[i]) begin
                if (bram_we) mem[i][bram_addr] <= bram_din;
                else if (corrupt && bram_addr == 10'd1) r1[i] <= 18'h3;
                else r1[i] <= mem[i][bram_addr];
            end
            r2[i] <= r1[i];
        end
    end

    always_comb begin
        bram_dout = '0;
        for (int i = 0; i < NP; i++) begin
            bram_dout[i*18 +: 18] = (LAT == 2) ? r2[i] : r1[i];
        end
    end

    typedef struct {
        logic [2:0]        tgt;
        logic [AW:0]       len;
        logic              vfy;
        logic              stall;
        logic              cor;
        logic [3:0][17:0]  w;
        logic [1:0]        e_err;
        logic [NP-1:0]     e_rst;
        int                e_wr;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tv [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [2:0] t, int len, bit vfy, bit st,
                                bit cor, logic [17:0] a, logic [17:0] b,
                                logic [17:0] c, logic [17:0] d,
                                logic [1:0] e, logic [NP-1:0] r, int ew);
        vec_t v;
        v.tgt = t; v.len = (AW+1)'(len); v.vfy = vfy; v.stall = st;
        v.cor = cor; v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
        v.e_err = e; v.e_rst = r; v.e_wr = ew;
        return v;
    endfunction

    function automatic logic [17:0] word(vec_t v, int i);
        logic [1:0] ix;
        ix = 2'(i);
        return (i < 4) ? v.w[ix] : 18'(i * 7 + 5);
    endfunction

    function automatic logic [NP-1:0] oh(logic [2:0] t);
        logic [NP-1:0] o;
        for (int k = 0; k < NP; k++) o[k] = (t == 3'(k));
        return o;
    endfunction

    task automatic run(input vec_t v, input string nm);
        int acc = 0, wr = 0, rd = 0, viol = 0;
        int holdc = 0, rstc = 0, dones = 0, after = 0, exp_rd;
        logic seen_busy = 1'b0;
        logic done_seen = 1'b0;
        logic [NP-1:0] o, others0;
        o       = oh(v.tgt);
        others0 = pb_reset & ~o;
        corrupt = v.cor;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = v.tgt;
        bus.cmd_len    = v.len;
        bus.cmd_verify = v.vfy;
        bus.s_valid    = 1'b1;
        bus.s_data     = word(v, 0);
        @(negedge clk);
        chk({nm, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        for (int c = 0; c < 8000 && after < 3; c++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            bus.s_valid   = v.stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            bus.s_data    = word(v, acc);
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
            if (done) dones++;
            if (bram_we) begin
                if (bram_en != o || bram_addr != AW'(wr) ||
                    bram_din != word(v, wr) || !bus.s_valid) viol++;
                wr++;
            end else if (bram_en != '0) begin
                if (bram_en != o || bram_addr != AW'(rd)) viol++;
                rd++;
            end
            if (bus.s_valid && bus.s_ready) acc++;
            if ((pb_reset & o) != '0) begin
                rstc++;
                if (!bus.s_ready && wr == 0) holdc++;
            end
            if ((pb_reset & ~o) != others0) viol++;
            if (done_seen) after++;
            if (done) done_seen = 1'b1;
        end
        bus.s_valid = 1'b0;
        exp_rd = (v.e_err == ERR_CMD || !v.vfy) ? 0 : v.e_wr;
        chk({nm, " done_seen"}, 32'(done_seen), 32'd1);
        chk({nm, " done_pulses"}, 32'(dones), 32'd1);
        chk({nm, " err"}, 32'(err), 32'(v.e_err));
        chk({nm, " writes"}, 32'(wr), 32'(v.e_wr));
        chk({nm, " reads"}, 32'(rd), 32'(exp_rd));
        chk({nm, " port_viol"}, 32'(viol), 32'd0);
        chk({nm, " pb_reset"}, 32'(pb_reset), 32'(v.e_rst));
        if (v.e_err == ERR_CMD) begin
            chk({nm, " busy_seen"}, 32'(seen_busy), 32'd0);
        end else begin
            chk({nm, " hold_before_write"}, 32'(holdc), 32'(HOLD));
        end
        if (v.e_err == ERR_OK) begin
            chk({nm, " reset_span_ok"},
                32'(rstc >= 2 * HOLD + int'(v.len)), 32'd1);
        end
    endtask

    initial begin
        int wr, acc, dones;
        vec_t pv;
        bus.cmd_valid  = 1'b0;
        bus.cmd_target = '0;
        bus.cmd_len    = '0;
        bus.cmd_verify = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;

        tv[0] = mk(3'd2, 4, 0, 0, 0, 18'h1, 18'h2, 18'h3, 18'h4,
                   ERR_OK, 4'b0000, 4);
        tv[1] = mk(3'd0, 3, 1, 0, 0, 18'h3FFFF, 18'h2, 18'h1, 18'h0,
                   ERR_OK, 4'b0000, 3);
        tv[2] = mk(3'd0, 3, 1, 0, 1, 18'h3FFFF, 18'h2, 18'h1, 18'h0,
                   ERR_SUM, 4'b0001, 3);
        tv[3] = mk(3'd4, 4, 0, 0, 0, 18'h1, 18'h2, 18'h3, 18'h4,
                   ERR_CMD, 4'b0001, 0);
        tv[4] = mk(3'd7, 4, 1, 0, 0, 18'h1, 18'h2, 18'h3, 18'h4,
                   ERR_CMD, 4'b0001, 0);
        tv[5] = mk(3'd1, 0, 0, 0, 0, 18'h1, 18'h2, 18'h3, 18'h4,
                   ERR_CMD, 4'b0001, 0);
        tv[6] = mk(3'd1, 1025, 0, 0, 0, 18'h1, 18'h2, 18'h3, 18'h4,
                   ERR_CMD, 4'b0001, 0);
        tv[7] = mk(3'd0, 1, 0, 0, 0, 18'h155, 18'h0, 18'h0, 18'h0,
                   ERR_OK, 4'b0000, 1);
        tv[8] = mk(3'd3, 1024, 1, 1, 0, 18'h10, 18'h20, 18'h30, 18'h40,
                   ERR_OK, 4'b0000, 1024);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst bram", 32'({bram_en, bram_we, bram_addr}), 32'd0);
        chk("rst bram_din", 32'(bram_din), 32'd0);
        chk("rst status", 32'({pb_reset, busy, done, err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run(tv[i], $sformatf("vec%0d", i));
        end

        corrupt = 1'b0;
        wr = 0;
        acc = 0;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = 3'd1;
        bus.cmd_len    = 11'd8;
        bus.cmd_verify = 1'b0;
        bus.s_valid    = 1'b1;
        bus.s_data     = 18'd100;
        for (int c = 0; c < 100 && wr < 5; c++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            bus.s_data    = 18'(100 + acc);
            @(negedge clk);
            if (bram_we) wr++;
            if (bus.s_valid && bus.s_ready) acc++;
        end
        chk("abort reached_word5", 32'(wr), 32'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort bram_en", 32'(bram_en), 32'd0);
        chk("abort pb_reset", 32'(pb_reset), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
        dones = done ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort no_done", 32'(dones), 32'd0);

        pv = mk(3'd1, 2, 1, 0, 0, 18'h111, 18'h222, 18'h0, 18'h0,
                ERR_OK, 4'b0000, 2);
        run(pv, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
